// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: fetch PC, in-order req/gnt/rvalid fetch, prefetch FIFO, redirect flush.
// Optional macro IFU_PREFETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module ifu_prefetch #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [2:0]  Hold_If  = 3'b010;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    logic [31:0]           pc_q, pc_d;
    logic                  active_q;
    logic                  pend_q, pend_d;
    logic [31:0]           pend_addr_q;
    logic                  kill_pend_q, kill_pend_d;
    logic [CW-1:0]         kill_cnt_q, kill_cnt_d;
    logic [CW-1:0]         alloc_cnt_q, alloc_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         fill_ptr_q, fill_ptr_d;
    logic [31:0]           ent_addr_q [FIFO_DEPTH];
    logic [31:0]           ent_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_filled_q;

    logic          hold_en;
    logic [CW-1:0] filled_cnt;
    logic [CW-1:0] unfilled_cnt;
    logic          head_filled;
    logic          rsp_kill;
    logic          fill_en;
    logic          bypass_vld;
    logic          bypass_pop;
    logic          pop;
    logic [CW:0]   occ;
    logic [CW:0]   kill_sum;
    logic          grant;
    logic          stale_gnt;
    logic          alloc_en;
    logic          unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];

    always_comb begin
        hold_en    = (hold_flag_i >= Hold_If);
        filled_cnt = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            filled_cnt = filled_cnt + CW'(ent_filled_q[i]);
        end
        unfilled_cnt = alloc_cnt_q - filled_cnt;
        head_filled  = ent_filled_q[rd_ptr_q];
        rsp_kill     = mem_rvalid_i & (kill_cnt_q != '0);
        // Responses are in order, so a live response always lands in the oldest unfilled slot.
        fill_en      = mem_rvalid_i & (kill_cnt_q == '0) & (unfilled_cnt != '0) & !jump_flag_i;
`ifdef IFU_PREFETCH_BYPASS_EN
        bypass_vld   = fill_en & (filled_cnt == '0);
`else
        bypass_vld   = 1'b0;
`endif
        inst_valid_o = !jump_flag_i & (head_filled | bypass_vld);
        pop          = inst_valid_o & !hold_en;
        bypass_pop   = bypass_vld & !hold_en;

        inst_o      = INST_NOP;
        inst_addr_o = ZeroWord;
        if (!jump_flag_i && head_filled) begin
            inst_o      = ent_data_q[rd_ptr_q];
            inst_addr_o = ent_addr_q[rd_ptr_q];
        end
`ifdef IFU_PREFETCH_BYPASS_EN
        else if (bypass_vld) begin
            inst_o      = mem_rdata_i;
            inst_addr_o = ent_addr_q[fill_ptr_q];
        end
`endif
    end

    // Words still owed by memory for a flushed stream count against the depth as well.
    always_comb begin
        occ        = {1'b0, alloc_cnt_q} + {1'b0, kill_cnt_q} - (CW+1)'(pop);
        mem_req_o  = pend_q | (active_q & !jump_flag_i & (occ < (CW+1)'(FIFO_DEPTH)));
        mem_addr_o = pend_q ? pend_addr_q : pc_q;
        grant      = mem_req_o & mem_gnt_i;
        stale_gnt  = grant & (kill_pend_q | jump_flag_i);
        alloc_en   = grant & !stale_gnt;
    end

    always_comb begin
        pend_d      = mem_req_o & !mem_gnt_i;
        kill_pend_d = pend_d & (kill_pend_q | jump_flag_i);
        kill_sum    = '0;
        if (jump_flag_i) begin
            pc_d        = {jump_addr_i[31:2], 2'b00};
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_ptr_d  = '0;
            alloc_cnt_d = '0;
            // Any response this cycle is dropped here rather than counted.
            kill_sum    = {1'b0, kill_cnt_q} + {1'b0, unfilled_cnt} + (CW+1)'(stale_gnt)
                        - (CW+1)'(mem_rvalid_i & ((kill_cnt_q | unfilled_cnt) != '0));
            kill_cnt_d  = kill_sum[CW-1:0];
        end else begin
            pc_d        = alloc_en ? pc_q + 32'd4 : pc_q;
            wr_ptr_d    = wr_ptr_q + PW'(alloc_en);
            rd_ptr_d    = rd_ptr_q + PW'(pop);
            fill_ptr_d  = fill_ptr_q + PW'(fill_en);
            alloc_cnt_d = alloc_cnt_q + CW'(alloc_en) - CW'(pop);
            kill_cnt_d  = kill_cnt_q - CW'(rsp_kill) + CW'(stale_gnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            active_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= RESET_PC;
            kill_pend_q <= 1'b0;
            kill_cnt_q  <= '0;
            alloc_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_ptr_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            active_q    <= 1'b1;
            pend_q      <= pend_d;
            pend_addr_q <= mem_addr_o;
            kill_pend_q <= kill_pend_d;
            kill_cnt_q  <= kill_cnt_d;
            alloc_cnt_q <= alloc_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
            ent_filled_q <= '0;
        end else if (jump_flag_i) begin
            ent_filled_q <= '0;
        end else begin
            if (alloc_en) begin
                ent_addr_q[wr_ptr_q]   <= mem_addr_o;
                ent_filled_q[wr_ptr_q] <= 1'b0;
            end
            // A bypassed word is consumed directly and never lands in the FIFO.
            if (fill_en && !bypass_pop) begin
                ent_data_q[fill_ptr_q]   <= mem_rdata_i;
                ent_filled_q[fill_ptr_q] <= 1'b1;
            end
            if (pop) begin
                ent_filled_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

endmodule
